// File: rtl/store_merge_unit.sv
// Store path for sw/sb/sh: sw writes directly, sb/sh do read-modify-write on the low lane.
// Optional alignment rejection of sw/sh is compiled in with STORE_ALIGN_CHECK_EN.
module store_merge_unit #(
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        Start,
   input  logic [1:0]  Store_size,
   input  logic [31:0] Addr,
   input  logic [31:0] Store_data,
   input  logic [31:0] Mem_rdata,
   output logic [31:0] Mem_addr,
   output logic        Mem_re,
   output logic        Mem_we,
   output logic [31:0] Mem_wdata,
   output logic        Busy,
   output logic        Done,
   output logic        Error
);

   typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_t;

   state_t      r_state, w_state_d;
   logic [3:0]  r_cnt, w_cnt_d;
   logic [1:0]  r_size, w_size_d;
   logic [15:0] r_data, w_data_d;
   logic [31:0] r_mem_addr, w_mem_addr_d;
   logic [31:0] r_mem_wdata, w_mem_wdata_d;
   logic        r_mem_re, w_mem_re_d;
   logic        r_mem_we, w_mem_we_d;
   logic        r_busy, w_busy_d;
   logic        r_done, w_done_d;
   logic        r_error, w_error_d;
   logic        w_reject;
   logic [31:0] w_merged;

`ifdef STORE_ALIGN_CHECK_EN
   always_comb begin
      w_reject = (Store_size == 2'b11)
                 || ((Store_size == 2'b00) && (Addr[1:0] != 2'b00))
                 || ((Store_size == 2'b10) && Addr[0]);
   end
`else
   always_comb begin
      w_reject = (Store_size == 2'b11);
   end
`endif

   // Low-lane merge, matching the load path's extraction convention
   always_comb begin
      if (r_size == 2'b01) begin
         w_merged = {Mem_rdata[31:8], r_data[7:0]};
      end else begin
         w_merged = {Mem_rdata[31:16], r_data};
      end
   end

   // Outputs are registered from next-state values so they align with the state they describe
   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_size_d      = r_size;
      w_data_d      = r_data;
      w_mem_addr_d  = r_mem_addr;
      w_mem_wdata_d = r_mem_wdata;
      w_mem_re_d    = 1'b0;
      w_mem_we_d    = 1'b0;
      w_done_d      = 1'b0;
      w_error_d     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (Start) begin
               if (w_reject) begin
                  w_error_d = 1'b1;
               end else begin
                  w_size_d     = Store_size;
                  w_data_d     = Store_data[15:0];
                  w_mem_addr_d = Addr;
                  if (Store_size == 2'b00) begin
                     w_state_d     = StWrite;
                     w_mem_we_d    = 1'b1;
                     w_mem_wdata_d = Store_data;
                  end else begin
                     w_state_d  = StRead;
                     w_mem_re_d = 1'b1;
                  end
               end
            end
         end
         StRead: begin
            w_cnt_d   = 4'(MEM_RD_LAT);
            w_state_d = StWait;
         end
         StWait: begin
            w_cnt_d = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_d     = StWrite;
               w_mem_we_d    = 1'b1;
               w_mem_wdata_d = w_merged;
            end
         end
         StWrite: begin
            w_state_d = StDone;
            w_done_d  = 1'b1;
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
      w_busy_d = (w_state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_size      <= 2'b00;
         r_data      <= 16'd0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_size      <= w_size_d;
         r_data      <= w_data_d;
         r_mem_addr  <= w_mem_addr_d;
         r_mem_wdata <= w_mem_wdata_d;
         r_mem_re    <= w_mem_re_d;
         r_mem_we    <= w_mem_we_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_error     <= w_error_d;
      end
   end

   assign Mem_addr  = r_mem_addr;
   assign Mem_re    = r_mem_re;
   assign Mem_we    = r_mem_we;
   assign Mem_wdata = r_mem_wdata;
   assign Busy      = r_busy;
   assign Done      = r_done;
   assign Error     = r_error;

endmodule
